// File: rtl/ifq_pkg.sv
// ifq_pkg: shared constants for the instruction fetch queue and the decode
// stage that consumes its output.
//   NOP_INS     - canonical RISC-V NOP (addi x0, x0, 0), shown when the queue is empty
//   OPC_*       - major opcodes of the control-flow instructions
//   is_ctrl_flow_opcode() - classifies a 7-bit major opcode as control flow
package ifq_pkg;

    localparam logic [31:0] NOP_INS    = 32'h00000013;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    function automatic logic is_ctrl_flow_opcode(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/ifq_if.sv
// ifq_if: bundle of the enqueue (fetch side) and dequeue (decode side)
// handshakes of the instruction fetch queue, plus flush and occupancy.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high and flush_in is low. The producer
// must hold valid and its payload stable until the transfer; ready never
// depends on valid of the same channel. flush_in cancels both transfers of
// that cycle.
//
// Modports:
//   slave  - the queue itself (accepts enqueues, offers dequeues)
//   master - the surrounding pipeline (fetch unit + decode stage)
interface ifq_if #(
    parameter int PTR_WIDTH  = 2,
    parameter int DATA_WIDTH = 32
);
    logic                  enq_valid_in;
    logic [DATA_WIDTH-1:0] enq_pc_in;
    logic [DATA_WIDTH-1:0] enq_ins_in;
    logic                  enq_ready_out;
    logic                  deq_ready_in;
    logic                  deq_valid_out;
    logic [DATA_WIDTH-1:0] deq_pc_out;
    logic [DATA_WIDTH-1:0] deq_ins_out;
    logic                  deq_ctrl_flow_out;
    logic                  flush_in;
    logic [PTR_WIDTH:0]    count_out;

    modport slave (
        input  enq_valid_in, enq_pc_in, enq_ins_in, deq_ready_in, flush_in,
        output enq_ready_out, deq_valid_out, deq_pc_out, deq_ins_out,
               deq_ctrl_flow_out, count_out
    );

    modport master (
        output enq_valid_in, enq_pc_in, enq_ins_in, deq_ready_in, flush_in,
        input  enq_ready_out, deq_valid_out, deq_pc_out, deq_ins_out,
               deq_ctrl_flow_out, count_out
    );
endinterface

// File: rtl/ifq_predecode.sv
// ifq_predecode: combinational predecoder on the enqueue path.
//   ins       in  32  instruction word being enqueued
//   ctrl_flow out  1  instruction is JAL, JALR or a conditional branch
module ifq_predecode
    import ifq_pkg::*;
(
    input  logic [31:0] ins,
    output logic        ctrl_flow
);
    // Only the major opcode decides control flow; the remaining bits are
    // folded into a sink so the full word can stay on the port.
    logic unused_ins_bits;

    assign unused_ins_bits = ^ins[31:7];
    assign ctrl_flow       = is_ctrl_flow_opcode(ins[6:0]);
endmodule

// File: rtl/ifq.sv
// ifq: instruction fetch queue between the fetch unit and decode.
// Circular buffer of DEPTH {pc, ins, ctrl_flow} entries; ctrl_flow is
// predecoded on enqueue. Dequeue outputs come straight from the head entry
// (no same-cycle bypass, so an enqueued entry is visible one cycle later).
//   ifq_clock_in  in   clock, all state changes on the rising edge
//   ifq_reset_in  in   synchronous active-high reset (pointers and count only)
//   bus           ifq_if.slave: enqueue/dequeue handshakes, flush, count_out
module ifq
    import ifq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic  ifq_clock_in,
    input  logic  ifq_reset_in,
    ifq_if.slave  bus
);
    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    // Entry storage has no reset: a stale entry is never visible because
    // deq_valid_out is derived from count.
    logic [DATA_WIDTH-1:0] pc_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] ins_mem [DEPTH];
    logic                  cf_mem  [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH:0]   count;

    logic enq_ready;
    logic deq_valid;
    logic enq_fire;
    logic deq_fire;
    logic enq_ctrl_flow;

    ifq_predecode u_predecode (
        .ins       (bus.enq_ins_in),
        .ctrl_flow (enq_ctrl_flow)
    );

    // Ready ignores deq_ready_in on purpose: a full queue never accepts,
    // even when the head leaves in the same cycle.
    assign enq_ready = !ifq_reset_in && (count != FULL_COUNT);
    assign deq_valid = (count != '0);
    assign enq_fire  = bus.enq_valid_in && enq_ready && !bus.flush_in;
    assign deq_fire  = deq_valid && bus.deq_ready_in && !bus.flush_in;

    always_ff @(posedge ifq_clock_in) begin
        if (ifq_reset_in || bus.flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + (PTR_WIDTH + 1)'(1);
                2'b01:   count <= count - (PTR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // enq_fire already excludes reset and flush.
    always_ff @(posedge ifq_clock_in) begin
        if (enq_fire) begin
            pc_mem[wr_ptr]  <= bus.enq_pc_in;
            ins_mem[wr_ptr] <= bus.enq_ins_in;
            cf_mem[wr_ptr]  <= enq_ctrl_flow;
        end
    end

    // An empty queue presents a NOP so decode sees a harmless word.
    always_comb begin
        bus.deq_pc_out        = '0;
        bus.deq_ins_out       = DATA_WIDTH'(NOP_INS);
        bus.deq_ctrl_flow_out = 1'b0;
        if (deq_valid) begin
            bus.deq_pc_out        = pc_mem[rd_ptr];
            bus.deq_ins_out       = ins_mem[rd_ptr];
            bus.deq_ctrl_flow_out = cf_mem[rd_ptr];
        end
    end

    assign bus.enq_ready_out = enq_ready;
    assign bus.deq_valid_out = deq_valid;
    assign bus.count_out     = count;
endmodule
